rocket_dmem_responder: RTL and testbench
========================================

// Module: rocket_dmem_responder
// PURPOSE
//  Memory-side responder for the Rocket core's io_dmem_* (HellaCache) port.
//  It stands in for the L1 data cache in subsystem benches. It accepts core
//  requests, runs the s0/s1/s2 pipeline timing, and returns load data from an
//  internal word array. It also applies masked stores and raises nack and
//  exception flags.
// PARAMETERS
//  MEM_WORDS   1024            number of 64-bit backing words (power of 2)
//  BASE_ADDR   40'h80000000    byte address of word 0
//  NACK_EVERY  0               nack every Nth non-killed s2 request; 0=never
//  READY_GAP   0               cycles req_ready stays low after each accept
// PORTS
//  clock                        in   1   clock
//  reset                        in   1   sync active-high reset
//  io_dmem_req_ready            out  1   responder can accept in s0
//  io_dmem_req_valid            in   1   core request valid
//  io_dmem_req_bits_addr        in   40  byte address
//  io_dmem_req_bits_tag         in   7   request tag, echoed on resp
//  io_dmem_req_bits_cmd         in   5   0=XRD load, 1=XWR store; others=store
//  io_dmem_req_bits_typ         in   3   [1:0] log2 size, [2] unsigned
//  io_dmem_req_bits_phys        in   1   ignored (no translation)
//  io_dmem_s1_kill              in   1   kill request currently in s1
//  io_dmem_s1_data_data         in   64  store data, valid in s1
//  io_dmem_s1_data_mask         in   8   store byte mask, valid in s1
//  io_dmem_s2_nack              out  1   request in s2 rejected
//  io_dmem_resp_valid           out  1   load response valid
//  io_dmem_resp_bits_tag        out  7   tag of responding load
//  io_dmem_resp_bits_typ        out  3   typ of responding load
//  io_dmem_resp_bits_data       out  64  extended load data
//  io_dmem_resp_bits_data_word_bypass out 64 raw aligned 64-bit word
//  io_dmem_resp_bits_replay     out  1   always 0
//  io_dmem_resp_bits_has_data   out  1   1 with every resp_valid
//  io_dmem_replay_next          out  1   always 0
//  io_dmem_s2_xcpt_{ma,pf,ae}_{ld,st} out 1 each  s2 exception flags; pf always 0
//  io_dmem_invalidate_lr        in   1   ignored
//  io_dmem_ordered              out  1   no request in s1 or s2
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1 and ordered=1. s1/s2 valid
//    cleared, nack and gap counters cleared. Memory contents not reset.
//  - s0: accept on req_valid&&req_ready. Latch addr/tag/cmd/typ into s1.
//  - s1: sample s1_data_data/mask. If s1_kill, drop the request (no s2).
//  - s2, one cycle after s1:
//    - ma = addr & ((1<<typ[1:0])-1) != 0.
//    - ae = word index (addr-BASE_ADDR)>>3 outside [0,MEM_WORDS). ma has
//      priority, so ae is not raised when ma is set.
//    - ld/st flag chosen by cmd==0.
//  - nack: asserted when NACK_EVERY!=0 and the s2 sequence count hits
//    NACK_EVERY-1; the counter then wraps to 0. A nacked request has no
//    side effects, no resp, and no xcpt flags.
//  - Load (no xcpt, no nack):
//    - resp_valid in s2, i.e. 2 cycles after accept.
//    - data = field at byte offset addr[2:0], sign-extended unless typ[2].
//  - Store (no xcpt, no nack): write mask bytes into the word at the s2 edge.
//    No resp.
//  - Read-after-write: an s2 load to a word being stored in the same s2 slot
//    cannot occur. A back-to-back store then load to the same word must
//    return the new data, so the store commits before the load's s2 read.
//  - req_ready drops for READY_GAP cycles after each accept, then rises.
//    READY_GAP=0 gives full throughput, one request per cycle.
//  - reset asserted mid-flight: s1/s2 requests are discarded. No resp or
//    store occurs on or after the reset cycle.
// STRUCTURE
//  - Shared package rocket_dmem_pkg holds:
//    - M_XRD and M_XWR constants
//    - the typ_t struct (size, unsigned)
//    - the s1/s2 pipeline-register struct dmem_stage_t
//  - One sub-module, rocket_dmem_ldext: combinational byte/half/word select
//    plus sign/zero extension from (word, offset, typ).
// TESTING
//  - Store dword 0x1122334455667788 @0x80000000, mask 0xFF, then load typ=3
//    -> resp 2 cycles after accept, data 0x1122334455667788, tag echoed.
//  - Load typ=0 signed @0x80000007 (byte 0x11) -> 0x11.
//    Store 0x80 there, then load typ=0 signed -> 0xFFFFFFFFFFFFFF80; typ=4
//    -> 0x80.
//  - Load typ=2 @0x80000002 -> xcpt_ma_ld=1, resp_valid=0.
//    Store @BASE+8*MEM_WORDS -> xcpt_ae_st=1, memory unchanged.
//  - s1_kill on an accepted store -> no write; a later load returns the old
//    value, and ordered returns to 1 one cycle after kill.
//  - NACK_EVERY=3, 6 back-to-back loads -> s2_nack on the 3rd and 6th only.
//    Those have no resp; the others respond in order with correct tags.
//  - Reset asserted while a load sits in s1 -> no resp_valid afterwards.
//    req_ready=1 and ordered=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/rocket_dmem_pkg.sv
// Shared types and constants for the Rocket dmem responder.
//  - M_XRD / M_XWR : memory command encodings (anything other than XRD stores)
//  - typ_t         : access type, {unsigned, log2 size}
//  - dmem_stage_t  : s1/s2 pipeline register contents
package rocket_dmem_pkg;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  // Bit 2 selects zero extension, bits [1:0] are log2 of the access size.
  typedef struct packed {
    logic       uns;
    logic [1:0] size;
  } typ_t;

  typedef struct packed {
    logic        valid;
    logic [39:0] addr;
    logic [6:0]  tag;
    logic [4:0]  cmd;
    typ_t        typ;
    logic [63:0] data;
    logic [7:0]  mask;
  } dmem_stage_t;

endpackage

// File: rtl/rocket_dmem.sv
// Word-index helper for the dmem responder: maps a byte address to a backing
// word index and flags addresses outside the backing array.
module rocket_dmem_word_index #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [39:0] BASE_ADDR = 40'h80000000
) (
  input  logic [39:0]                  addr_i,
  output logic [$clog2(MEM_WORDS)-1:0] idx_o,
  output logic                         oob_o
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic [39:0] offs;
  logic [2:0]  unused_low;

  always_comb begin
    offs       = addr_i - BASE_ADDR;
    idx_o      = offs[IdxW+2:3];
    // Addresses below the base wrap to huge offsets and land out of range.
    oob_o      = offs[39:3] >= 37'(MEM_WORDS);
    unused_low = offs[2:0];
  end

endmodule

// File: rtl/rocket_dmem_ldext.sv
// Load data extractor: picks the byte/half/word/dword field at a byte offset
// inside an aligned 64-bit word and sign- or zero-extends it to 64 bits.
//  word_i   : aligned 64-bit memory word
//  offset_i : byte offset within the word (addr[2:0])
//  typ_i    : access size and signedness
//  data_o   : extended load data
module rocket_dmem_ldext
  import rocket_dmem_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  offset_i,
  input  typ_t        typ_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    data_o  = shifted;
    unique case (typ_i.size)
      2'd0: data_o = typ_i.uns ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: data_o = typ_i.uns ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: data_o = typ_i.uns ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: data_o = shifted;
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/rocket_dmem_responder.sv
// Memory-side responder for the Rocket core HellaCache (io_dmem_*) port.
// Models the L1 data cache s0/s1/s2 timing over an internal 64-bit word array:
// loads respond in s2, masked stores commit at the end of s2, and s2 raises
// misaligned / access-fault flags and optional periodic nacks.
//  clock, reset (sync, active-high)
//  io_dmem_req_*     : s0 request handshake and fields
//  io_dmem_s1_*      : s1 kill and store data/mask
//  io_dmem_s2_*      : s2 nack and exception flags
//  io_dmem_resp_*    : load response
//  io_dmem_ordered   : no request in flight in s1 or s2
module rocket_dmem_responder
  import rocket_dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [39:0] BASE_ADDR  = 40'h80000000,
  parameter int unsigned NACK_EVERY = 0,
  parameter int unsigned READY_GAP  = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_dmem_req_ready,
  input  logic        io_dmem_req_valid,
  input  logic [39:0] io_dmem_req_bits_addr,
  input  logic [6:0]  io_dmem_req_bits_tag,
  input  logic [4:0]  io_dmem_req_bits_cmd,
  input  logic [2:0]  io_dmem_req_bits_typ,
  input  logic        io_dmem_req_bits_phys,
  input  logic        io_dmem_s1_kill,
  input  logic [63:0] io_dmem_s1_data_data,
  input  logic [7:0]  io_dmem_s1_data_mask,
  output logic        io_dmem_s2_nack,
  output logic        io_dmem_resp_valid,
  output logic [6:0]  io_dmem_resp_bits_tag,
  output logic [2:0]  io_dmem_resp_bits_typ,
  output logic [63:0] io_dmem_resp_bits_data,
  output logic [63:0] io_dmem_resp_bits_data_word_bypass,
  output logic        io_dmem_resp_bits_replay,
  output logic        io_dmem_resp_bits_has_data,
  output logic        io_dmem_replay_next,
  output logic        io_dmem_s2_xcpt_ma_ld,
  output logic        io_dmem_s2_xcpt_ma_st,
  output logic        io_dmem_s2_xcpt_pf_ld,
  output logic        io_dmem_s2_xcpt_pf_st,
  output logic        io_dmem_s2_xcpt_ae_ld,
  output logic        io_dmem_s2_xcpt_ae_st,
  input  logic        io_dmem_invalidate_lr,
  output logic        io_dmem_ordered
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned GapW = (READY_GAP == 0) ? 1 : $clog2(READY_GAP + 1);
  localparam int unsigned CntW = (NACK_EVERY <= 1) ? 1 : $clog2(NACK_EVERY);
  localparam bit          NackEn = (NACK_EVERY != 0);
  localparam logic [CntW-1:0] NackLast = (NACK_EVERY == 0) ? '0 : CntW'(NACK_EVERY - 1);
  localparam logic [GapW-1:0] GapLoad  = GapW'(READY_GAP);

  logic [63:0] mem_q [MEM_WORDS];

  dmem_stage_t     s1_q, s1_d, s2_q, s2_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [CntW-1:0] nack_cnt_q, nack_cnt_d;

  logic            accept;
  logic            s2_live;
  logic            s2_is_load;
  logic            s2_ma, s2_ae, s2_nack, s2_ok;
  logic [2:0]      align_mask;
  logic [IdxW-1:0] s2_idx;
  logic [63:0]     s2_word, s2_ext;
  logic            do_store;
  logic            unused_inputs;

  assign unused_inputs = io_dmem_req_bits_phys ^ io_dmem_invalidate_lr;

  // s0 accept and s1/s2 next state
  always_comb begin
    io_dmem_req_ready = reset || (gap_q == '0);
    accept            = io_dmem_req_valid && io_dmem_req_ready && !reset;

    s1_d       = s1_q;
    s1_d.valid = accept;
    if (accept) begin
      s1_d.addr = io_dmem_req_bits_addr;
      s1_d.tag  = io_dmem_req_bits_tag;
      s1_d.cmd  = io_dmem_req_bits_cmd;
      s1_d.typ  = typ_t'(io_dmem_req_bits_typ);
      s1_d.data = '0;
      s1_d.mask = '0;
    end

    // Store data arrives in s1, so it is captured on the s1 -> s2 move.
    s2_d       = s1_q;
    s2_d.valid = s1_q.valid && !io_dmem_s1_kill;
    s2_d.data  = io_dmem_s1_data_data;
    s2_d.mask  = io_dmem_s1_data_mask;

    gap_d = gap_q;
    if (accept) begin
      gap_d = GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  rocket_dmem_word_index #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) u_index (
    .addr_i(s2_q.addr),
    .idx_o (s2_idx),
    .oob_o (s2_ae)
  );

  // s2 decode; everything is gated by reset so nothing leaks out mid-reset.
  always_comb begin
    s2_live    = s2_q.valid && !reset;
    s2_is_load = (s2_q.cmd == M_XRD);
    unique case (s2_q.typ.size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b111;
    endcase
    s2_ma   = |(s2_q.addr[2:0] & align_mask);
    s2_nack = s2_live && NackEn && (nack_cnt_q == NackLast);
    s2_ok   = s2_live && !s2_nack && !s2_ma && !s2_ae;
    do_store = s2_ok && !s2_is_load;

    nack_cnt_d = nack_cnt_q;
    if (s2_live && NackEn) begin
      nack_cnt_d = (nack_cnt_q == NackLast) ? '0 : nack_cnt_q + 1'b1;
    end
  end

  // Combinational read in s2: a store committed at the previous edge is visible.
  assign s2_word = mem_q[s2_idx];

  rocket_dmem_ldext u_ldext (
    .word_i  (s2_word),
    .offset_i(s2_q.addr[2:0]),
    .typ_i   (s2_q.typ),
    .data_o  (s2_ext)
  );

  always_comb begin
    io_dmem_s2_nack       = s2_nack;
    io_dmem_resp_valid    = s2_ok && s2_is_load;
    io_dmem_resp_bits_tag = io_dmem_resp_valid ? s2_q.tag : '0;
    io_dmem_resp_bits_typ = io_dmem_resp_valid ? s2_q.typ : '0;
    io_dmem_resp_bits_data = io_dmem_resp_valid ? s2_ext : '0;
    io_dmem_resp_bits_data_word_bypass = io_dmem_resp_valid ? s2_word : '0;
    io_dmem_resp_bits_replay   = 1'b0;
    io_dmem_resp_bits_has_data = io_dmem_resp_valid;
    io_dmem_replay_next        = 1'b0;
    io_dmem_s2_xcpt_ma_ld = s2_live && !s2_nack && s2_ma && s2_is_load;
    io_dmem_s2_xcpt_ma_st = s2_live && !s2_nack && s2_ma && !s2_is_load;
    io_dmem_s2_xcpt_pf_ld = 1'b0;
    io_dmem_s2_xcpt_pf_st = 1'b0;
    // Misalignment wins, so ae only fires on aligned accesses.
    io_dmem_s2_xcpt_ae_ld = s2_live && !s2_nack && !s2_ma && s2_ae && s2_is_load;
    io_dmem_s2_xcpt_ae_st = s2_live && !s2_nack && !s2_ma && s2_ae && !s2_is_load;
    io_dmem_ordered       = reset || (!s1_q.valid && !s2_q.valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      gap_q      <= '0;
      nack_cnt_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      gap_q      <= gap_d;
      nack_cnt_q <= nack_cnt_d;
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (do_store) begin
      for (int b = 0; b < 8; b++) begin
        if (s2_q.mask[b]) begin
          mem_q[s2_idx][8*b +: 8] <= s2_q.data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rocket_dmem_responder.sv
module tb_rocket_dmem_responder;
  import rocket_dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [39:0] req_addr;
  logic [6:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic        s1_kill;
  logic [63:0] s1_data;
  logic [7:0]  s1_mask;

  // Outputs of the plain instance (no nacks)
  logic        ready, nack, rvalid, replay, has_data, replay_next, ordered;
  logic [6:0]  rtag;
  logic [2:0]  rtyp;
  logic [63:0] rdata, rbypass;
  logic        ma_ld, ma_st, pf_ld, pf_st, ae_ld, ae_st;

  // Outputs of the NACK_EVERY=3 instance
  logic        ready_n, nack_n, rvalid_n, replay_n, has_data_n, replay_next_n, ordered_n;
  logic [6:0]  rtag_n;
  logic [2:0]  rtyp_n;
  logic [63:0] rdata_n, rbypass_n;
  logic        ma_ld_n, ma_st_n, pf_ld_n, pf_st_n, ae_ld_n, ae_st_n;

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Values captured by do_req
  logic        early_valid, r_valid, r_ma_ld, r_ma_st, r_ae_ld, r_ae_st, r_nack;
  logic        ord_s1, ord_s2;
  logic [6:0]  r_tag;
  logic [63:0] r_data, r_bypass;

  always #5 clock = ~clock;

  rocket_dmem_responder dut (
    .clock(clock), .reset(reset),
    .io_dmem_req_ready(ready), .io_dmem_req_valid(req_valid),
    .io_dmem_req_bits_addr(req_addr), .io_dmem_req_bits_tag(req_tag),
    .io_dmem_req_bits_cmd(req_cmd), .io_dmem_req_bits_typ(req_typ),
    .io_dmem_req_bits_phys(1'b1), .io_dmem_s1_kill(s1_kill),
    .io_dmem_s1_data_data(s1_data), .io_dmem_s1_data_mask(s1_mask),
    .io_dmem_s2_nack(nack), .io_dmem_resp_valid(rvalid),
    .io_dmem_resp_bits_tag(rtag), .io_dmem_resp_bits_typ(rtyp),
    .io_dmem_resp_bits_data(rdata), .io_dmem_resp_bits_data_word_bypass(rbypass),
    .io_dmem_resp_bits_replay(replay), .io_dmem_resp_bits_has_data(has_data),
    .io_dmem_replay_next(replay_next),
    .io_dmem_s2_xcpt_ma_ld(ma_ld), .io_dmem_s2_xcpt_ma_st(ma_st),
    .io_dmem_s2_xcpt_pf_ld(pf_ld), .io_dmem_s2_xcpt_pf_st(pf_st),
    .io_dmem_s2_xcpt_ae_ld(ae_ld), .io_dmem_s2_xcpt_ae_st(ae_st),
    .io_dmem_invalidate_lr(1'b0), .io_dmem_ordered(ordered)
  );

  rocket_dmem_responder #(.NACK_EVERY(3)) dut_n (
    .clock(clock), .reset(reset),
    .io_dmem_req_ready(ready_n), .io_dmem_req_valid(req_valid),
    .io_dmem_req_bits_addr(req_addr), .io_dmem_req_bits_tag(req_tag),
    .io_dmem_req_bits_cmd(req_cmd), .io_dmem_req_bits_typ(req_typ),
    .io_dmem_req_bits_phys(1'b1), .io_dmem_s1_kill(s1_kill),
    .io_dmem_s1_data_data(s1_data), .io_dmem_s1_data_mask(s1_mask),
    .io_dmem_s2_nack(nack_n), .io_dmem_resp_valid(rvalid_n),
    .io_dmem_resp_bits_tag(rtag_n), .io_dmem_resp_bits_typ(rtyp_n),
    .io_dmem_resp_bits_data(rdata_n), .io_dmem_resp_bits_data_word_bypass(rbypass_n),
    .io_dmem_resp_bits_replay(replay_n), .io_dmem_resp_bits_has_data(has_data_n),
    .io_dmem_replay_next(replay_next_n),
    .io_dmem_s2_xcpt_ma_ld(ma_ld_n), .io_dmem_s2_xcpt_ma_st(ma_st_n),
    .io_dmem_s2_xcpt_pf_ld(pf_ld_n), .io_dmem_s2_xcpt_pf_st(pf_st_n),
    .io_dmem_s2_xcpt_ae_ld(ae_ld_n), .io_dmem_s2_xcpt_ae_st(ae_st_n),
    .io_dmem_invalidate_lr(1'b0), .io_dmem_ordered(ordered_n)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Issue one request from a negedge; returns at the negedge after its s2 cycle.
  task automatic do_req(input logic [4:0] cmd, input logic [39:0] addr, input logic [6:0] tag,
                        input logic [2:0] typ, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic kill);
    req_valid = 1'b1; req_addr = addr; req_tag = tag; req_cmd = cmd; req_typ = typ;
    @(negedge clock);
    req_valid = 1'b0; s1_data = wdata; s1_mask = wmask; s1_kill = kill;
    early_valid = rvalid;
    ord_s1      = ordered;
    @(negedge clock);
    s1_kill = 1'b0; s1_data = '0; s1_mask = '0;
    r_valid = rvalid; r_tag = rtag; r_data = rdata; r_bypass = rbypass;
    r_ma_ld = ma_ld; r_ma_st = ma_st; r_ae_ld = ae_ld; r_ae_st = ae_st; r_nack = nack;
    ord_s2  = ordered;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_tag = '0; req_cmd = '0;
    req_typ = '0; s1_kill = 1'b0; s1_data = '0; s1_mask = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_ordered", 64'(ordered), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_nack", 64'(nack_n), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_ordered", 64'(ordered), 64'd1);

    // Six back-to-back loads; the NACK_EVERY=3 instance rejects the 3rd and 6th.
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        int k;
        k = c - 2;
        check($sformatf("nack%0d", k), 64'(nack_n), 64'((k == 2) || (k == 5)));
        check($sformatf("nvalid%0d", k), 64'(rvalid_n), 64'(!((k == 2) || (k == 5))));
        if (!((k == 2) || (k == 5))) check($sformatf("ntag%0d", k), 64'(rtag_n), 64'(k + 1));
        check($sformatf("pvalid%0d", k), 64'(rvalid), 64'd1);
        check($sformatf("pnack%0d", k), 64'(nack), 64'd0);
      end
      req_valid = (c < 6); req_addr = 40'h80000000; req_cmd = M_XRD; req_typ = 3'd3;
      req_tag = 7'(c + 1);
      @(negedge clock);
    end
    req_valid = 1'b0;

    // Dword store then load
    do_req(M_XWR, 40'h80000000, 7'h05, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0);
    check("st_noresp", 64'(r_valid), 64'd0);
    check("st_noxcpt", 64'({r_ma_st, r_ae_st}), 64'd0);
    do_req(M_XRD, 40'h80000000, 7'h2A, 3'd3, '0, '0, 1'b0);
    check("ld_s1_quiet", 64'(early_valid), 64'd0);
    check("ld_valid", 64'(r_valid), 64'd1);
    check("ld_data", r_data, 64'h1122334455667788);
    check("ld_tag", 64'(r_tag), 64'h2A);
    check("ld_bypass", r_bypass, 64'h1122334455667788);

    // Byte loads and a byte store at offset 7
    do_req(M_XRD, 40'h80000007, 7'h01, 3'd0, '0, '0, 1'b0);
    check("lb_11", r_data, 64'h11);
    do_req(M_XWR, 40'h80000007, 7'h02, 3'd0, 64'h8000000000000000, 8'h80, 1'b0);
    do_req(M_XRD, 40'h80000007, 7'h03, 3'd0, '0, '0, 1'b0);
    check("lb_80s", r_data, 64'hFFFFFFFFFFFFFF80);
    do_req(M_XRD, 40'h80000007, 7'h04, 3'd4, '0, '0, 1'b0);
    check("lbu_80", r_data, 64'h80);
    do_req(M_XRD, 40'h80000006, 7'h05, 3'd1, '0, '0, 1'b0);
    check("lh_8022", r_data, 64'hFFFFFFFFFFFF8022);
    do_req(M_XRD, 40'h80000004, 7'h06, 3'd2, '0, '0, 1'b0);
    check("lw_s", r_data, 64'hFFFFFFFF80223344);
    do_req(M_XRD, 40'h80000004, 7'h07, 3'd6, '0, '0, 1'b0);
    check("lwu", r_data, 64'h0000000080223344);
    do_req(M_XRD, 40'h80000000, 7'h08, 3'd0, '0, '0, 1'b0);
    check("lb_88", r_data, 64'hFFFFFFFFFFFFFF88);

    // Exceptions
    do_req(M_XRD, 40'h80000002, 7'h09, 3'd2, '0, '0, 1'b0);
    check("ma_ld", 64'(r_ma_ld), 64'd1);
    check("ma_noresp", 64'(r_valid), 64'd0);
    check("ma_noae", 64'(r_ae_ld), 64'd0);
    do_req(M_XWR, 40'h80002000, 7'h0A, 3'd3, 64'h5555555555555555, 8'hFF, 1'b0);
    check("ae_st", 64'(r_ae_st), 64'd1);
    check("ae_noma", 64'(r_ma_st), 64'd0);
    do_req(M_XRD, 40'h7FFFFFF8, 7'h0B, 3'd3, '0, '0, 1'b0);
    check("ae_ld", 64'(r_ae_ld), 64'd1);
    check("ae_noresp", 64'(r_valid), 64'd0);
    do_req(M_XRD, 40'h80000000, 7'h0C, 3'd3, '0, '0, 1'b0);
    check("ae_memkeep", r_data, 64'h8022334455667788);

    // Killed store leaves memory alone
    do_req(M_XWR, 40'h80000008, 7'h0D, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    do_req(M_XWR, 40'h80000008, 7'h0E, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    check("kill_ord_s1", 64'(ord_s1), 64'd0);
    check("kill_ord_s2", 64'(ord_s2), 64'd1);
    do_req(M_XRD, 40'h80000008, 7'h0F, 3'd3, '0, '0, 1'b0);
    check("kill_old", r_data, 64'h0123456789ABCDEF);

    // Store immediately followed by a load of the same word
    req_valid = 1'b1; req_addr = 40'h80000010; req_cmd = M_XWR; req_typ = 3'd3; req_tag = 7'h10;
    @(negedge clock);
    s1_data = 64'hCAFEBABE00C0FFEE; s1_mask = 8'hFF;
    req_addr = 40'h80000010; req_cmd = M_XRD; req_tag = 7'h11;
    @(negedge clock);
    req_valid = 1'b0; s1_data = '0; s1_mask = '0;
    @(negedge clock);
    check("raw_valid", 64'(rvalid), 64'd1);
    check("raw_tag", 64'(rtag), 64'h11);
    check("raw_data", rdata, 64'hCAFEBABE00C0FFEE);
    @(negedge clock);

    // Reset while a load sits in s1
    req_valid = 1'b1; req_addr = 40'h80000000; req_cmd = M_XRD; req_typ = 3'd3; req_tag = 7'h12;
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("mrst_rvalid", 64'(rvalid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("mrst_ready", 64'(ready), 64'd1);
    check("mrst_ordered", 64'(ordered), 64'd1);
    check("mrst_rvalid2", 64'(rvalid), 64'd0);
    @(negedge clock);
    check("mrst_rvalid3", 64'(rvalid), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
